// File: rtl/iterative_divider_24bits_24bits.sv
// Sequential restoring divider, 48/24 full or 24/12 half precision, one quotient bit per cycle.
// Define DIVIDER_ERR_CHECK_EN for overflow / divide-by-zero early-out with o_err reporting.
module iterative_divider_24bits_24bits (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_Numerical_Precision,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [47:0] C_NUM,
  input  logic [23:0] B_NUM,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [23:0] Q_NUM,
  output logic [23:0] R_NUM,
  output logic        o_err
);

  localparam int unsigned W  = 24;
  localparam int unsigned HW = 12;
  localparam int unsigned CW = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] PREC_FULL = 2'b11;

  logic [1:0]    state_q, state_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rmd_q, rmd_d;
  logic          err_q, err_d;

  logic          full_c;
  logic          ovf_c;
  logic [W:0]    rem_sh_c;
  logic          ge_c;
  logic [W-1:0]  sub_c;

  assign full_c = (i_Numerical_Precision == PREC_FULL);

`ifdef DIVIDER_ERR_CHECK_EN
  // Overflow: quotient would not fit, which also covers a zero divisor.
  assign ovf_c = full_c ? (C_NUM[47:24] >= B_NUM)
                        : (C_NUM[23:12] >= B_NUM[11:0]);
`else
  assign ovf_c = 1'b0;
`endif

  // N+1-bit partial remainder: next dividend bit enters from the MSB of dvd_q.
  assign rem_sh_c = {rem_q, dvd_q[W-1]};
  assign ge_c     = (rem_sh_c >= {1'b0, div_q});
  assign sub_c    = rem_sh_c[W-1:0] - div_q;

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = valid_q;
  assign Q_NUM   = quo_q;
  assign R_NUM   = rmd_q;
  assign o_err   = err_q;

  // Next-state and datapath; half mode left-aligns its low dividend half in dvd_q.
  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_RUN;
          full_d  = full_c;
          ovf_d   = ovf_c;
          if (full_c) begin
            rem_d = C_NUM[47:24];
            dvd_d = C_NUM[23:0];
            div_d = B_NUM;
            cnt_d = CW'(W);
          end else begin
            rem_d = {12'd0, C_NUM[23:12]};
            dvd_d = {C_NUM[11:0], 12'd0};
            div_d = {12'd0, B_NUM[11:0]};
            cnt_d = CW'(HW);
          end
          if (ovf_c) cnt_d = '0;
        end
      end

      S_RUN: begin
        if (cnt_q != '0) begin
          rem_d = ge_c ? sub_c : rem_sh_c[W-1:0];
          dvd_d = {dvd_q[W-2:0], ge_c};
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_DONE;
          valid_d = 1'b1;
          if (ovf_q) begin
            quo_d = full_q ? 24'hFFFFFF : 24'h000FFF;
            rmd_d = '0;
            err_d = 1'b1;
          end else begin
            quo_d = full_q ? dvd_q : {12'd0, dvd_q[11:0]};
            rmd_d = full_q ? rem_q : {12'd0, rem_q[11:0]};
            err_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_iterative_divider_24bits_24bits.sv
// Scoreboard bench for iterative_divider_24bits_24bits: directed vectors, decoupled monitor.
module tb_iterative_divider_24bits_24bits;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  prec = 2'b11;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [47:0] c_num = '0;
  logic [23:0] b_num = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [23:0] q_num;
  logic [23:0] r_num;
  logic        o_err;

  typedef struct {
    logic [23:0] q;
    logic [23:0] r;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   vld_prev = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  iterative_divider_24bits_24bits dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_Numerical_Precision (prec),
    .i_valid               (i_valid),
    .o_ready               (o_ready),
    .C_NUM                 (c_num),
    .B_NUM                 (b_num),
    .o_valid               (o_valid),
    .i_ready               (i_ready),
    .Q_NUM                 (q_num),
    .R_NUM                 (r_num),
    .o_err                 (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation; operands are scrambled right after accept to prove they were latched.
  task automatic issue(input logic [1:0] p, input logic [47:0] c, input logic [23:0] b,
                       input logic [23:0] q, input logic [23:0] r, input logic e, input int lat);
    int   guard = 0;
    exp_t x;
    @(posedge clk); #1;
    prec = p; c_num = c; b_num = b; i_valid = 1'b1;
    while (!o_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 48'd0, 48'd1);
      i_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    prec = ~p; c_num = ~c; b_num = ~b;
    x.q = q; x.r = r; x.err = e; x.lat = lat; x.acc = cyc;
    sb.push_back(x);
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || have_cur || !o_ready) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) chk("drain_timeout", 48'd0, 48'd1);
  endtask

  // Monitor: on each rising o_valid pop an expectation; check it every cycle the result is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      vld_prev = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (o_valid) begin
        if (!vld_prev) begin
          if (sb.size() == 0) chk("unexpected_valid", 48'd1, 48'd0);
          else begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            chk("latency", 48'(cyc - cur.acc), 48'(cur.lat));
          end
        end
        if (have_cur) begin
          chk("Q_NUM", 48'(q_num), 48'(cur.q));
          chk("R_NUM", 48'(r_num), 48'(cur.r));
          chk("o_err", 48'(o_err), 48'(cur.err));
          chk("o_ready_in_done", 48'(o_ready), 48'd0);
          if (i_ready) have_cur = 1'b0;
        end
      end
      vld_prev = o_valid;
    end
  end

  initial begin
    int g;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_Q", 48'(q_num), 48'd0);
    chk("rst_R", 48'(r_num), 48'd0);
    chk("rst_valid", 48'(o_valid), 48'd0);
    chk("rst_err", 48'(o_err), 48'd0);
    chk("rst_ready", 48'(o_ready), 48'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(2'b11, 48'd1000000, 24'd7, 24'd142857, 24'd1, 1'b0, 25);
    drain();
    issue(2'b01, 48'hFFFFFF00C350, 24'hABC12C, 24'd166, 24'd200, 1'b0, 13);
    drain();
    issue(2'b11, 48'hFFFFFE000001, 24'hFFFFFF, 24'hFFFFFF, 24'd0, 1'b0, 25);
    drain();
    issue(2'b10, 48'h123456FFE001, 24'h987FFF, 24'h000FFF, 24'd0, 1'b0, 13);
    drain();
    issue(2'b11, 48'h000000ABCDEF, 24'd1, 24'hABCDEF, 24'd0, 1'b0, 25);
    drain();

    // Backpressure: result held, new requests ignored, one handshake on release.
    i_ready = 1'b0;
    issue(2'b11, 48'd123456789, 24'd1000, 24'd123456, 24'd789, 1'b0, 25);
    g = 0;
    while (!o_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("bp_valid_seen", 48'(o_valid), 48'd1);
    repeat (10) begin
      @(posedge clk); #1;
      prec = 2'b11; c_num = 48'd50; b_num = 24'd5; i_valid = 1'b1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_ready_after_hs", 48'(o_ready), 48'd1);
    chk("bp_valid_after_hs", 48'(o_valid), 48'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("bp_no_extra_job", 48'(o_ready), 48'd1);

    // Reset after iteration 10 of a full-mode divide aborts without a result.
    issue(2'b11, 48'd1000000, 24'd7, 24'd142857, 24'd1, 1'b0, 25);
    repeat (10) @(posedge clk);
    #2;
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("abort_Q", 48'(q_num), 48'd0);
    chk("abort_R", 48'(r_num), 48'd0);
    chk("abort_valid", 48'(o_valid), 48'd0);
    chk("abort_err", 48'(o_err), 48'd0);
    chk("abort_ready", 48'(o_ready), 48'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_still_idle", 48'(o_ready), 48'd1);
    issue(2'b11, 48'd100, 24'd9, 24'd11, 24'd1, 1'b0, 25);
    drain();

`ifdef DIVIDER_ERR_CHECK_EN
    issue(2'b11, 48'd5, 24'd0, 24'hFFFFFF, 24'd0, 1'b1, 1);
    drain();
    issue(2'b00, 48'h000000010000, 24'h000010, 24'h000FFF, 24'd0, 1'b1, 1);
    drain();
`endif

    issue(2'b01, 48'd50000, 24'd300, 24'd166, 24'd200, 1'b0, 13);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
